// File: rtl/rv_elastic_buffer.sv
// ---------------------------------------------------------------------------
// rv_elastic_buffer
//   Parametrised ready/valid elastic buffer between a streaming source and
//   sink on a single clock. DEPTH-entry circular store with registered
//   handshake flags, an occupancy count, an almost-full flag, a synchronous
//   flush and a sticky high-water mark. Every output is driven from flops
//   (dat_o through the storage read mux only), so there is no combinational
//   path from either side of the buffer to the other.
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   arst          in   asynchronous active-high reset
//   flush         in   synchronous discard of all stored words
//   valid_i       in   source word valid
//   dat_i         in   source word [WIDTH]
//   ready_i       out  buffer can accept a word (registered)
//   valid_o       out  head word valid (registered)
//   dat_o         out  head word [WIDTH]
//   ready_o       in   sink accepts head word
//   count_o       out  occupancy 0..DEPTH [CW] (registered)
//   almost_full_o out  count_o >= AF_LEVEL (registered)
//   max_count_o   out  sticky high-water mark of count_o [CW]
// ---------------------------------------------------------------------------
module rv_elastic_buffer #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             flush,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] dat_o,
    input  logic             ready_o,
    output logic [CW-1:0]    count_o,
    output logic             almost_full_o,
    output logic [CW-1:0]    max_count_o
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    max_q, max_d;
    logic             valid_q, ready_q, af_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] we;

    logic push, pop;

    // Handshakes are qualified only by registered flags, keeping both
    // boundaries free of combinational feed-through.
    assign push = valid_i & ready_q;
    assign pop  = valid_q & ready_o;

    // Per-entry write enables; a push in a flush cycle is dropped.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign we[gi] = push & ~flush & (wr_q == PW'(gi));
    end

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;

        // Explicit wrap compare so DEPTH need not be a power of two.
        if (push) wr_d = (wr_q == LAST_P) ? '0 : wr_q + ONE_P;
        if (pop)  rd_d = (rd_q == LAST_P) ? '0 : rd_q + ONE_P;

        if (push && !pop)      count_d = count_q + ONE_C;
        else if (pop && !push) count_d = count_q - ONE_C;

        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end

        if (flush)                max_d = '0;
        else if (count_d > max_q) max_d = count_d;
        else                      max_d = max_q;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            max_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            max_q   <= max_d;
            // Flags are computed from the next occupancy so they are
            // correct in the cycle right after the edge.
            valid_q <= (count_d != '0);
            ready_q <= (count_d < DEPTH_C);
            af_q    <= (count_d >= AF_C);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we[i]) mem_q[i] <= dat_i;
            end
        end
    end

    assign ready_i       = ready_q;
    assign valid_o       = valid_q;
    assign dat_o         = mem_q[rd_q];
    assign count_o       = count_q;
    assign almost_full_o = af_q;
    assign max_count_o   = max_q;

`ifndef SYNTHESIS
    int ptr_diff;
    always_comb begin
        if (wr_q >= rd_q) ptr_diff = int'(wr_q) - int'(rd_q);
        else              ptr_diff = int'(wr_q) + DEPTH - int'(rd_q);
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            assert (!(push && count_q == DEPTH_C))
                else $error("rv_elastic_buffer: push while full");
            assert (!(pop && count_q == '0))
                else $error("rv_elastic_buffer: pop while empty");
            // Equal pointers mean empty or full; count disambiguates.
            assert ((count_q == DEPTH_C) ? (ptr_diff == 0) : (ptr_diff == int'(count_q)))
                else $error("rv_elastic_buffer: count/pointer disagreement");
        end
    end
`endif

endmodule

// File: tb/tb_rv_elastic_buffer.sv
// ---------------------------------------------------------------------------
// tb_rv_elastic_buffer
//   Two buffers share clk/arst: index 0 is DEPTH=4, index 1 is DEPTH=3.
//   A per-instance occupancy model plus a scoreboard queue supplies every
//   expected value; step() checks outputs, advances the model and clocks.
// ---------------------------------------------------------------------------
module tb_rv_elastic_buffer;

    localparam int DEP [2] = '{4, 3};
    localparam int AFL [2] = '{3, 2};

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        flush [2];
    logic        vin   [2];
    logic        rout  [2];
    logic [15:0] din   [2];

    logic        rdy0, vld0, af0;
    logic [15:0] dout0;
    logic [2:0]  cnt0, mx0;
    logic        rdy1, vld1, af1;
    logic [15:0] dout1;
    logic [1:0]  cnt1, mx1;

    int errors = 0;
    int checks = 0;

    int          cnt_m  [2];
    int          mx_m   [2];
    bit          fresh  [2];
    bit          last_push [2];
    logic [15:0] sb0 [$];
    logic [15:0] sb1 [$];

    always #5 clk = ~clk;

    rv_elastic_buffer #(.WIDTH(16), .DEPTH(4)) dut4 (
        .clk(clk), .arst(arst), .flush(flush[0]),
        .valid_i(vin[0]), .dat_i(din[0]), .ready_i(rdy0),
        .valid_o(vld0), .dat_o(dout0), .ready_o(rout[0]),
        .count_o(cnt0), .almost_full_o(af0), .max_count_o(mx0)
    );

    rv_elastic_buffer #(.WIDTH(16), .DEPTH(3)) dut3 (
        .clk(clk), .arst(arst), .flush(flush[1]),
        .valid_i(vin[1]), .dat_i(din[1]), .ready_i(rdy1),
        .valid_o(vld1), .dat_o(dout1), .ready_o(rout[1]),
        .count_o(cnt1), .almost_full_o(af1), .max_count_o(mx1)
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[d%0d] observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            cnt_m[d] = 0;
            mx_m[d]  = 0;
            fresh[d] = 1'b1;
        end
        sb0.delete();
        sb1.delete();
    endtask

    // Check current outputs against the model, account for this cycle's
    // handshakes, then advance one clock.
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            logic [15:0] od;
            logic [2:0]  oc, om;
            logic        orr, ov, oa;
            logic        exp_rdy, p, q;
            logic [15:0] front;
            if (d == 0) begin
                od = dout0; oc = cnt0; om = mx0; orr = rdy0; ov = vld0; oa = af0;
            end else begin
                od = dout1; oc = {1'b0, cnt1}; om = {1'b0, mx1}; orr = rdy1; ov = vld1; oa = af1;
            end
            exp_rdy = fresh[d] ? 1'b0 : (cnt_m[d] < DEP[d]);
            chk("count", d, 32'(oc), 32'(cnt_m[d]));
            chk("ready_i", d, 32'(orr), 32'(exp_rdy));
            chk("valid_o", d, 32'(ov), 32'(cnt_m[d] != 0));
            chk("almost_full", d, 32'(oa), 32'(cnt_m[d] >= AFL[d]));
            chk("max_count", d, 32'(om), 32'(mx_m[d]));
            if (cnt_m[d] != 0) begin
                front = (d == 0) ? sb0[0] : sb1[0];
                chk("dat_o", d, 32'(od), 32'(front));
            end
            p = vin[d] & exp_rdy & ~flush[d];
            q = (cnt_m[d] != 0) & rout[d] & ~flush[d];
            if (q) begin
                if (d == 0) void'(sb0.pop_front());
                else        void'(sb1.pop_front());
            end
            if (p) begin
                if (d == 0) sb0.push_back(din[d]);
                else        sb1.push_back(din[d]);
            end
            last_push[d] = p;
            fresh[d] = 1'b0;
            if (flush[d]) begin
                cnt_m[d] = 0;
                mx_m[d]  = 0;
                if (d == 0) sb0.delete();
                else        sb1.delete();
            end else begin
                cnt_m[d] = cnt_m[d] + int'(p) - int'(q);
                if (cnt_m[d] > mx_m[d]) mx_m[d] = cnt_m[d];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int d);
        vin[d]  = 1'b0;
        rout[d] = 1'b1;
        for (int c = 0; c < 12 && cnt_m[d] != 0; c++) step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0; vin[d] = 1'b0; rout[d] = 1'b0; din[d] = '0;
        end
        model_reset();

        // Reset values, then release between edges.
        arst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 0, 32'(rdy0), 0);
        chk("rst_valid", 0, 32'(vld0), 0);
        chk("rst_count", 0, 32'(cnt0), 0);
        chk("rst_dat", 0, 32'(dout0), 0);
        chk("rst_ready", 1, 32'(rdy1), 0);
        chk("rst_dat", 1, 32'(dout1), 0);
        @(negedge clk);
        arst = 1'b0;
        step();
        step();

        // Continuous stream with sink always ready.
        rout[0] = 1'b1;
        vin[0]  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            din[0] = 16'(i);
            step();
        end
        drain(0);
        chk("stream_max", 0, 32'(mx0), 1);
        chk("stream_empty", 0, 32'(vld0), 0);

        // Fill while the sink stalls, then release it.
        idx = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            vin[0]  = 1'b1;
            din[0]  = 16'(16'hA0 + idx);
            rout[0] = (c >= 8);
            if (c == 5) begin
                chk("full_ready", 0, 32'(rdy0), 0);
                chk("full_count", 0, 32'(cnt0), 4);
                chk("full_dat", 0, 32'(dout0), 32'h00A0);
            end
            step();
            if (last_push[0]) idx++;
        end
        drain(0);
        chk("full_max", 0, 32'(mx0), 4);

        // DEPTH=3 with random stalls on both sides.
        idx = 0;
        for (int c = 0; c < 300 && idx < 10; c++) begin
            vin[1]  = 1'($urandom_range(0, 1));
            din[1]  = 16'(16'h0300 + idx);
            rout[1] = 1'($urandom_range(0, 1));
            step();
            if (last_push[1]) idx++;
        end
        drain(1);
        chk("d3_words_sent", 1, 32'(idx), 10);
        chk("d3_empty", 1, 32'(vld1), 0);

        // Fill to three, then flush with a concurrent push.
        rout[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin[0] = 1'b1;
            din[0] = 16'(16'hD0 + i);
            step();
        end
        flush[0] = 1'b1;
        vin[0]   = 1'b1;
        din[0]   = 16'hBEEF;
        step();
        flush[0] = 1'b0;
        vin[0]   = 1'b0;
        chk("flush_count", 0, 32'(cnt0), 0);
        chk("flush_valid", 0, 32'(vld0), 0);
        chk("flush_ready", 0, 32'(rdy0), 1);
        chk("flush_max", 0, 32'(mx0), 0);
        step();
        rout[0] = 1'b1;
        step();
        chk("flush_no_beef", 0, 32'(vld0), 0);

        // Two words held, then asynchronous reset between edges.
        rout[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vin[0] = 1'b1;
            din[0] = 16'(16'hE0 + i);
            step();
        end
        vin[0] = 1'b0;
        #2;
        arst = 1'b1;
        #1;
        chk("arst_valid", 0, 32'(vld0), 0);
        chk("arst_count", 0, 32'(cnt0), 0);
        chk("arst_ready", 0, 32'(rdy0), 0);
        chk("arst_dat", 0, 32'(dout0), 0);
        chk("arst_max", 0, 32'(mx0), 0);
        model_reset();
        @(negedge clk);
        arst = 1'b0;
        step();
        rout[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vin[0] = 1'b1;
            din[0] = 16'(16'hC1 + i);
            step();
        end
        drain(0);
        chk("post_arst_empty", 0, 32'(vld0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
